// File: rtl/pps_conditioner.sv
// PPS front-end: two-flop sync, glitch filter, period measurement and lock FSM gating the TDC trigger.
// Optional flywheel holdover is compiled in with `define PPS_HOLDOVER_EN.
module pps_conditioner #(
  parameter int unsigned NOMINAL_PERIOD  = 200000000,
  parameter int unsigned TOL_CYCLES      = 2000,
  parameter int unsigned MIN_HIGH_CYCLES = 4,
  parameter int unsigned LOCK_COUNT      = 3,
  parameter int unsigned CNT_W           = 32
`ifdef PPS_HOLDOVER_EN
  ,
  parameter int unsigned HOLDOVER_MAX    = 10
`endif
) (
  input  logic             clk200,
  input  logic             sys_reset_n,
  input  logic             pps_i,
  input  logic             arm_i,
  output logic             pps_pulse_o,
  output logic             tdc_pps_trigger_o,
  output logic             pps_locked_o,
  output logic             pps_missing_o,
  output logic [CNT_W-1:0] pps_period_o,
  output logic [1:0]       pps_state_o
);

  localparam int unsigned FLT_W  = $clog2(MIN_HIGH_CYCLES + 1);
  localparam int unsigned GOOD_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  PERIOD_LO = CNT_W'(NOMINAL_PERIOD - TOL_CYCLES);
  localparam logic [CNT_W-1:0]  PERIOD_HI = CNT_W'(NOMINAL_PERIOD + TOL_CYCLES);
  localparam logic [FLT_W-1:0]  FLT_ZERO  = {FLT_W{1'b0}};
  localparam logic [FLT_W-1:0]  FLT_ONE   = FLT_W'(32'd1);
  localparam logic [FLT_W-1:0]  FLT_FULL  = FLT_W'(MIN_HIGH_CYCLES);
  localparam logic [GOOD_W-1:0] GOOD_ZERO = {GOOD_W{1'b0}};
  localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(32'd1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);

`ifdef PPS_HOLDOVER_EN
  localparam int unsigned       HOLD_W    = $clog2(HOLDOVER_MAX + 2);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(32'd1);
  localparam logic [HOLD_W-1:0] HOLD_MAXV = HOLD_W'(HOLDOVER_MAX);
  localparam logic [CNT_W-1:0]  TOL_LOAD  = CNT_W'(TOL_CYCLES);
`endif

  typedef enum logic [1:0] {
    ST_SEARCH   = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_HOLDOVER = 2'd3
  } state_t;

  logic              sync1_r;
  logic              sync2_r;
  logic [FLT_W-1:0]  flt_cnt_r;
  logic              fired_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  period_r;
  state_t            state_r;
  state_t            state_nxt_s;
  logic [GOOD_W-1:0] good_cnt_r;
  logic [GOOD_W-1:0] good_nxt_s;
  logic              pulse_r;
  logic              trig_r;
  logic              missing_r;
  logic              locked_r;

  logic              event_s;
  logic              timeout_s;
  logic              synth_s;
  logic              pulse_s;
  logic              locked_like_s;
  logic              good_s;
  logic [CNT_W-1:0]  meas_s;

`ifdef PPS_HOLDOVER_EN
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [HOLD_W-1:0] hold_nxt_s;
`endif

  // Edge fires once per high run, on the first cycle the filter count is full.
  assign event_s       = (flt_cnt_r == FLT_FULL) && !fired_r;
  assign meas_s        = (cnt_r == CNT_MAX) ? CNT_MAX : (cnt_r + CNT_ONE);
  assign good_s        = (meas_s >= PERIOD_LO) && (meas_s <= PERIOD_HI);
  assign timeout_s     = (cnt_r == PERIOD_HI) && !event_s;
  assign locked_like_s = (state_r == ST_LOCKED) || (state_r == ST_HOLDOVER);
`ifdef PPS_HOLDOVER_EN
  assign synth_s       = timeout_s && locked_like_s;
`else
  assign synth_s       = 1'b0;
`endif
  assign pulse_s       = event_s || synth_s;

  // Two-flop synchroniser for the asynchronous PPS input.
  always_ff @(posedge clk200 or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= pps_i;
      sync2_r <= sync1_r;
    end
  end

  // Glitch filter: saturating high-run counter with a once-per-run fired flag.
  always_ff @(posedge clk200 or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      flt_cnt_r <= FLT_ZERO;
      fired_r   <= 1'b0;
    end else if (!sync2_r) begin
      flt_cnt_r <= FLT_ZERO;
      fired_r   <= 1'b0;
    end else begin
      if (flt_cnt_r != FLT_FULL) begin
        flt_cnt_r <= flt_cnt_r + FLT_ONE;
      end
      if (event_s) begin
        fired_r <= 1'b1;
      end
    end
  end

  // Period counter; synthetic pulses re-seed it at TOL so the flywheel stays on the nominal grid.
  always_ff @(posedge clk200 or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      cnt_r    <= CNT_ZERO;
      period_r <= CNT_ZERO;
    end else if (event_s) begin
      cnt_r    <= CNT_ZERO;
      period_r <= meas_s;
`ifdef PPS_HOLDOVER_EN
    end else if (synth_s) begin
      cnt_r    <= TOL_LOAD;
`endif
    end else if (cnt_r != CNT_MAX) begin
      cnt_r    <= cnt_r + CNT_ONE;
    end else begin
      cnt_r    <= cnt_r;
    end
  end

  // Lock FSM next-state logic; a real event always takes priority over a timeout.
  always_comb begin
    state_nxt_s = state_r;
    good_nxt_s  = good_cnt_r;
`ifdef PPS_HOLDOVER_EN
    hold_nxt_s  = hold_cnt_r;
`endif
    case (state_r)
      ST_SEARCH: begin
        if (event_s) begin
          state_nxt_s = ST_ACQUIRE;
          good_nxt_s  = GOOD_ZERO;
        end else begin
          state_nxt_s = ST_SEARCH;
        end
      end
      ST_ACQUIRE: begin
        if (event_s) begin
          if (!good_s) begin
            good_nxt_s = GOOD_ZERO;
          end else if (good_cnt_r == GOOD_LAST) begin
            state_nxt_s = ST_LOCKED;
            good_nxt_s  = GOOD_ZERO;
          end else begin
            good_nxt_s = good_cnt_r + GOOD_ONE;
          end
        end else if (timeout_s) begin
          state_nxt_s = ST_SEARCH;
          good_nxt_s  = GOOD_ZERO;
        end else begin
          state_nxt_s = ST_ACQUIRE;
        end
      end
      ST_LOCKED: begin
        if (event_s) begin
          if (good_s) begin
            state_nxt_s = ST_LOCKED;
          end else begin
            state_nxt_s = ST_ACQUIRE;
            good_nxt_s  = GOOD_ZERO;
          end
        end else if (timeout_s) begin
`ifdef PPS_HOLDOVER_EN
          hold_nxt_s  = HOLD_ONE;
          state_nxt_s = (HOLDOVER_MAX == 0) ? ST_SEARCH : ST_HOLDOVER;
`else
          state_nxt_s = ST_SEARCH;
`endif
        end else begin
          state_nxt_s = ST_LOCKED;
        end
      end
`ifdef PPS_HOLDOVER_EN
      ST_HOLDOVER: begin
        if (event_s) begin
          hold_nxt_s = HOLD_ZERO;
          if (good_s) begin
            state_nxt_s = ST_LOCKED;
          end else begin
            state_nxt_s = ST_ACQUIRE;
            good_nxt_s  = GOOD_ZERO;
          end
        end else if (timeout_s) begin
          if (hold_cnt_r >= HOLD_MAXV) begin
            state_nxt_s = ST_SEARCH;
            hold_nxt_s  = HOLD_ZERO;
          end else begin
            hold_nxt_s = hold_cnt_r + HOLD_ONE;
          end
        end else begin
          state_nxt_s = ST_HOLDOVER;
        end
      end
`endif
      default: begin
        state_nxt_s = ST_SEARCH;
        good_nxt_s  = GOOD_ZERO;
      end
    endcase
  end

  // Lock FSM state registers.
  always_ff @(posedge clk200 or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_r    <= ST_SEARCH;
      good_cnt_r <= GOOD_ZERO;
    end else begin
      state_r    <= state_nxt_s;
      good_cnt_r <= good_nxt_s;
    end
  end

`ifdef PPS_HOLDOVER_EN
  // Consecutive synthetic-pulse counter for holdover expiry.
  always_ff @(posedge clk200 or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      hold_cnt_r <= HOLD_ZERO;
    end else begin
      hold_cnt_r <= hold_nxt_s;
    end
  end
`endif

  // Registered outputs; the trigger uses the pre-event state so a locking edge never triggers.
  always_ff @(posedge clk200 or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      pulse_r   <= 1'b0;
      trig_r    <= 1'b0;
      missing_r <= 1'b0;
      locked_r  <= 1'b0;
    end else begin
      pulse_r   <= pulse_s;
      trig_r    <= pulse_s && arm_i && locked_like_s;
      missing_r <= timeout_s && (state_r != ST_SEARCH);
      locked_r  <= (state_nxt_s == ST_LOCKED) || (state_nxt_s == ST_HOLDOVER);
    end
  end

  assign pps_pulse_o       = pulse_r;
  assign tdc_pps_trigger_o = trig_r;
  assign pps_missing_o     = missing_r;
  assign pps_locked_o      = locked_r;
  assign pps_period_o      = period_r;
  assign pps_state_o       = state_r;

endmodule

// File: tb/tb_pps_conditioner.sv
// Randomised self-checking bench for pps_conditioner against a timestamp-based reference model.
module tb_pps_conditioner;

  localparam int NOM   = 1000;
  localparam int TOL   = 10;
  localparam int MINH  = 4;
  localparam int LOCKN = 3;
  localparam int HMAX  = 2;
`ifdef PPS_HOLDOVER_EN
  localparam bit HO = 1'b1;
`else
  localparam bit HO = 1'b0;
`endif

  logic        clk200      = 1'b0;
  logic        sys_reset_n = 1'b0;
  logic        pps_i       = 1'b0;
  logic        arm_i       = 1'b0;
  logic        pps_pulse_o;
  logic        tdc_pps_trigger_o;
  logic        pps_locked_o;
  logic        pps_missing_o;
  logic [31:0] pps_period_o;
  logic [1:0]  pps_state_o;

  int n_cmp = 0;
  int n_err = 0;

  pps_conditioner #(
    .NOMINAL_PERIOD(NOM),
    .TOL_CYCLES(TOL),
    .MIN_HIGH_CYCLES(MINH),
    .LOCK_COUNT(LOCKN),
    .CNT_W(32)
`ifdef PPS_HOLDOVER_EN
    ,
    .HOLDOVER_MAX(HMAX)
`endif
  ) dut (
    .clk200(clk200),
    .sys_reset_n(sys_reset_n),
    .pps_i(pps_i),
    .arm_i(arm_i),
    .pps_pulse_o(pps_pulse_o),
    .tdc_pps_trigger_o(tdc_pps_trigger_o),
    .pps_locked_o(pps_locked_o),
    .pps_missing_o(pps_missing_o),
    .pps_period_o(pps_period_o),
    .pps_state_o(pps_state_o)
  );

  always #5 clk200 = ~clk200;

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: edge index m_x, sample history, and an anchor time such that
  // the period counter value in the cycle before edge x equals x-1-m_anchor.
  int       m_x      = 0;
  int       m_anchor = 0;
  int       m_state  = 0;
  int       m_good   = 0;
  int       m_hold   = 0;
  int       m_period = 0;
  bit       m_pulse  = 1'b0;
  bit       m_trig   = 1'b0;
  bit       m_miss   = 1'b0;
  bit       m_locked = 1'b0;
  logic [7:0] hist   = 8'd0;
  bit       ev, to, syn, lk, good;
  int       cnt;

  always @(posedge clk200 or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      m_x = 0; m_anchor = 0; m_state = 0; m_good = 0; m_hold = 0; m_period = 0;
      m_pulse = 1'b0; m_trig = 1'b0; m_miss = 1'b0; m_locked = 1'b0; hist = 8'd0;
    end else begin
      m_x++;
      hist = {hist[6:0], pps_i};
      // A run of MINH highs starting at edge s produces its pulse at edge s+6.
      ev   = (hist[6:3] == 4'b1111) && !hist[7];
      cnt  = m_x - 1 - m_anchor;
      to   = (cnt == NOM + TOL) && !ev;
      lk   = (m_state == 2) || (m_state == 3);
      syn  = to && HO && lk;
      m_pulse = ev || syn;
      m_trig  = m_pulse && arm_i && lk;
      m_miss  = to && (m_state != 0);
      if (ev) begin
        m_period = cnt + 1;
        m_anchor = m_x;
        good = (m_period >= NOM - TOL) && (m_period <= NOM + TOL);
        if (m_state == 0) begin
          m_state = 1; m_good = 0;
        end else if (m_state == 1) begin
          if (good) begin
            m_good++;
            if (m_good >= LOCKN) begin m_state = 2; m_good = 0; end
          end else begin
            m_good = 0;
          end
        end else begin
          m_hold = 0;
          if (good) m_state = 2;
          else begin m_state = 1; m_good = 0; end
        end
      end else if (to && m_state != 0) begin
        if (m_state == 1 || !HO) begin
          m_state = 0; m_good = 0;
        end else begin
          m_hold++;
          m_anchor = m_x - TOL;
          if (m_hold > HMAX) begin m_state = 0; m_hold = 0; end
          else m_state = 3;
        end
      end
      m_locked = (m_state == 2) || (m_state == 3);
    end
  end

  // Compare on any active or expected pulse, plus a periodic full snapshot.
  always @(negedge clk200) begin
    if (m_pulse || pps_pulse_o || m_miss || pps_missing_o || m_trig || tdc_pps_trigger_o ||
        (m_x % 64 == 0)) begin
      check_value("pulse",   32'(pps_pulse_o),       32'(m_pulse));
      check_value("trigger", 32'(tdc_pps_trigger_o), 32'(m_trig));
      check_value("missing", 32'(pps_missing_o),     32'(m_miss));
      check_value("locked",  32'(pps_locked_o),      32'(m_locked));
      check_value("state",   32'(pps_state_o),       32'(m_state));
      check_value("period",  pps_period_o,           32'(m_period));
    end
  end

  task automatic tick(input logic p);
    @(negedge clk200);
    pps_i = p;
    arm_i = 1'($urandom_range(0, 1));
  endtask

  task automatic send_edge(input int period, input int width);
    for (int i = 0; i < period; i++) tick(i < width);
  endtask

  task automatic check_all_zero(input string tag);
    check_value({tag, "_pulse"},   32'(pps_pulse_o),       32'd0);
    check_value({tag, "_trigger"}, 32'(tdc_pps_trigger_o), 32'd0);
    check_value({tag, "_missing"}, 32'(pps_missing_o),     32'd0);
    check_value({tag, "_locked"},  32'(pps_locked_o),      32'd0);
    check_value({tag, "_state"},   32'(pps_state_o),       32'd0);
    check_value({tag, "_period"},  pps_period_o,           32'd0);
  endtask

  task automatic mid_reset(input int highs);
    for (int i = 0; i < highs; i++) tick(1'b1);
    @(posedge clk200);
    #2;
    sys_reset_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    repeat (2) @(negedge clk200);
    sys_reset_n = 1'b1;
    send_edge(700, 8);
  endtask

  int sel;
  int per;

  initial begin
    repeat (3) @(negedge clk200);
    check_all_zero("reset");
    sys_reset_n = 1'b1;
    repeat (5) tick(1'b0);

    for (int g = 0; g < 16; g++) begin
      sel = $urandom_range(1, 3);
      send_edge(sel + $urandom_range(2, 12), sel);
    end
    for (int g = 0; g < 4; g++) send_edge($urandom_range(20, 60), $urandom_range(4, 9));

    for (int e = 0; e < 30; e++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      per = $urandom_range(NOM - TOL, NOM + TOL);
      else if (sel == 6) per = ($urandom_range(0, 1) == 0) ? NOM - TOL : NOM + TOL;
      else if (sel == 7) per = ($urandom_range(0, 1) == 0) ? NOM - TOL - 1 : NOM + TOL + 1;
      else if (sel == 8) per = $urandom_range(300, 980);
      else               per = $urandom_range(1500, 3200);
      if (e == 12) mid_reset(3);
      if (e == 22) mid_reset(5);
      send_edge(per, $urandom_range(4, 30));
    end

    repeat (5) send_edge(NOM, 10);
    send_edge(NOM + TOL, 10);
    send_edge(NOM - TOL - 1, 10);
    repeat (4) send_edge(NOM, 10);
    send_edge(4000, 10);
    repeat (5) send_edge(NOM, 10);
    send_edge(2000, 10);
    repeat (3) send_edge(NOM, 10);
    repeat (20) tick(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
